// File: rtl/fpu_retire_pkg.sv
// fpu_retire shared types: queue entry, input packet, write-port bundle.
// Flag bit positions follow the {NV,DZ,OF,UF,NX} fflags layout.
package fpu_retire_pkg;

    localparam int FLAG_NX = 0;
    localparam int FLAG_UF = 1;
    localparam int FLAG_OF = 2;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_NV = 4;

    typedef struct packed {
        logic        fwren;
        logic        wren;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        fpuf;
        logic [4:0]  fflags;
    } fp_retire_entry_type;

    typedef struct packed {
        logic                valid;
        fp_retire_entry_type ent;
    } fp_retire_in_type;

    typedef struct packed {
        logic        fp_wren;
        logic [4:0]  fp_waddr;
        logic [31:0] fp_wdata;
        logic        int_wren;
        logic [4:0]  int_waddr;
        logic [31:0] int_wdata;
    } fp_retire_out_type;

    function automatic fp_retire_entry_type init_fp_retire_entry();
        return '0;
    endfunction

endpackage

// File: rtl/fpu_retire_if.sv
// Execute-to-retire result handshake (valid/ready plus result payload).
interface fpu_retire_if;

    logic        in_valid;
    logic        in_ready;
    logic        in_fwren;
    logic        in_wren;
    logic [4:0]  in_waddr;
    logic [31:0] in_wdata;
    logic        in_fpuf;
    logic [4:0]  in_fflags;

    modport master (
        output in_valid,
        output in_fwren,
        output in_wren,
        output in_waddr,
        output in_wdata,
        output in_fpuf,
        output in_fflags,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_fwren,
        input  in_wren,
        input  in_waddr,
        input  in_wdata,
        input  in_fpuf,
        input  in_fflags,
        output in_ready
    );

endinterface

// File: rtl/fpu_retire_fwd.sv
// Youngest-match search over the retire queue for FP result forwarding.
module fpu_retire_fwd #(
    parameter int DEPTH = 4
) (
    input  logic [DEPTH-1:0]         cand,
    input  logic [4:0]               addr [DEPTH],
    input  logic [31:0]              data [DEPTH],
    input  logic [$clog2(DEPTH)-1:0] wr_ptr,
    input  logic [4:0]               raddr,
    output logic                     hit,
    output logic [31:0]              rdata
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] idx;

    // Walk back from the newest slot so the first match is the youngest.
    always_comb begin
        hit   = 1'b0;
        rdata = '0;
        idx   = '0;
        for (int k = 1; k <= DEPTH; k++) begin
            idx = wr_ptr - AW'(k);
            if (!hit && cand[idx] && addr[idx] == raddr) begin
                hit   = 1'b1;
                rdata = data[idx];
            end
        end
    end

endmodule

// File: rtl/fpu_retire.sv
// FPU retire buffer: queues results, drains one per cycle, accrues fflags.
// Optional same-cycle bypass when empty: define FPU_RETIRE_BYPASS_EN.
module fpu_retire
    import fpu_retire_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    fpu_retire_if.slave in_if,
    input  logic        wb_stall,
    input  logic        flush,
    input  logic        flags_clr,
    output logic        fp_wren,
    output logic [4:0]  fp_waddr,
    output logic [31:0] fp_wdata,
    output logic        int_wren,
    output logic [4:0]  int_waddr,
    output logic [31:0] int_wdata,
    output logic [4:0]  fflags_acc,
    input  logic [4:0]  fwd_raddr,
    output logic        fwd_hit,
    output logic [31:0] fwd_data,
    output logic        empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fp_retire_entry_type mem [DEPTH];
    logic [DEPTH-1:0]    vld;
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [CW-1:0]       count;

    fp_retire_in_type    in_pkt;
    fp_retire_entry_type head;
    fp_retire_entry_type src;
    fp_retire_out_type   wb;

    logic full;
    logic push;
    logic pop;
    logic byp;
    logic go;

    always_comb begin
        in_pkt.valid      = in_if.in_valid;
        in_pkt.ent.fwren  = in_if.in_fwren;
        in_pkt.ent.wren   = in_if.in_wren;
        in_pkt.ent.waddr  = in_if.in_waddr;
        in_pkt.ent.wdata  = in_if.in_wdata;
        in_pkt.ent.fpuf   = in_if.in_fpuf;
        in_pkt.ent.fflags = in_if.in_fflags;
    end

    assign full           = (count == CW'(DEPTH));
    assign empty          = (count == '0);
    assign in_if.in_ready = !full;
    assign head           = mem[rd_ptr];
    assign pop            = !empty && !wb_stall;

`ifdef FPU_RETIRE_BYPASS_EN
    assign byp = empty && !wb_stall && !flush && in_pkt.valid;
`else
    assign byp = 1'b0;
`endif

    assign push = in_pkt.valid && !full && !flush && !byp;
    assign go   = pop || byp;

    always_comb begin
        src = init_fp_retire_entry();
        if (byp) src = in_pkt.ent;
        else     src = head;
    end

    always_comb begin
        wb.fp_wren   = go && src.fwren;
        wb.fp_waddr  = src.waddr;
        wb.fp_wdata  = src.wdata;
        wb.int_wren  = go && src.wren;
        wb.int_waddr = src.waddr;
        wb.int_wdata = src.wdata;
    end

    assign fp_wren   = wb.fp_wren;
    assign fp_waddr  = wb.fp_waddr;
    assign fp_wdata  = wb.fp_wdata;
    assign int_wren  = wb.int_wren;
    assign int_waddr = wb.int_waddr;
    assign int_wdata = wb.int_wdata;

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= in_pkt.ent;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            vld    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            vld    <= '0;
        end else begin
            if (push) begin
                vld[wr_ptr] <= 1'b1;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                vld[rd_ptr] <= 1'b0;
                rd_ptr      <= rd_ptr + 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // A CSR clear still keeps the flags of the op retiring alongside it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fflags_acc <= '0;
        end else if (flags_clr) begin
            fflags_acc <= (go && src.fpuf) ? src.fflags : 5'b0;
        end else if (go && src.fpuf) begin
            fflags_acc <= fflags_acc | src.fflags;
        end
    end

    logic [DEPTH-1:0] cand;
    logic [4:0]       q_addr [DEPTH];
    logic [31:0]      q_data [DEPTH];
    logic             q_hit;
    logic [31:0]      q_rdata;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            cand[i]   = vld[i] && mem[i].fwren;
            q_addr[i] = mem[i].waddr;
            q_data[i] = mem[i].wdata;
        end
    end

    fpu_retire_fwd #(
        .DEPTH (DEPTH)
    ) u_fwd (
        .cand   (cand),
        .addr   (q_addr),
        .data   (q_data),
        .wr_ptr (wr_ptr),
        .raddr  (fwd_raddr),
        .hit    (q_hit),
        .rdata  (q_rdata)
    );

`ifdef FPU_RETIRE_BYPASS_EN
    always_comb begin
        fwd_hit  = q_hit;
        fwd_data = q_rdata;
        if (byp && in_pkt.ent.fwren && in_pkt.ent.waddr == fwd_raddr) begin
            fwd_hit  = 1'b1;
            fwd_data = in_pkt.ent.wdata;
        end
    end
`else
    assign fwd_hit  = q_hit;
    assign fwd_data = q_rdata;
`endif

endmodule
